// File: rtl/freemode_seq.sv
// ---------------------------------------------------------------------------
// freemode_seq
//   Free-play mode with a hit queue. Every rising edge on i_hit captures the
//   current note key, length key and octave into a FIFO. A player FSM renders
//   the queued notes one after another: a square wave on o_buzzer, the
//   one-hot note on o_led, then a fixed silent gap. While i_en is low the
//   block is held idle: the queue is flushed and the octave is restored.
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous active-high reset (wins over i_en)
//   i_en          mode enable
//   i_hit         level input, rising edge enqueues a note
//   i_oct_up      level input, rising edge raises the octave (saturating)
//   i_oct_down    level input, rising edge lowers the octave (saturating)
//   i_note_key    note select, lowest set bit wins, all zero = rest
//   i_len_key     length select, bit k = 2^k units, all zero = 1 unit
//   o_buzzer      square-wave tone
//   o_led         one-hot copy of the note being played
//   o_octave      current octave register
//   o_busy        queue non-empty or player not idle (registered)
//   o_fifo_count  number of queued entries
//   o_ovf         one-cycle pulse when a hit is dropped on a full queue
// ---------------------------------------------------------------------------
module freemode_seq #(
    parameter int NOTES       = 7,
    parameter int CLK_HZ      = 100_000_000,
    parameter int UNIT_CYCLES = CLK_HZ / 8,
    parameter int GAP_CYCLES  = UNIT_CYCLES / 8,
    parameter int DEPTH       = 8,
    parameter int OCT_MIN     = 1,
    parameter int OCT_MAX     = 7,
    parameter int OCT_RESET   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic                       i_hit,
    input  logic                       i_oct_up,
    input  logic                       i_oct_down,
    input  logic [NOTES-1:0]           i_note_key,
    input  logic [3:0]                 i_len_key,
    output logic                       o_buzzer,
    output logic [NOTES-1:0]           o_led,
    output logic [2:0]                 o_octave,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_fifo_count,
    output logic                       o_ovf
);

    localparam int IDX_W = (NOTES > 1) ? $clog2(NOTES) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    // entry = {octave, note index, rest flag, log2(unit count)}
    localparam int ENT_W = 3 + IDX_W + 1 + 2;

    localparam logic [2:0]       OCT_MIN_C   = 3'(OCT_MIN);
    localparam logic [2:0]       OCT_MAX_C   = 3'(OCT_MAX);
    localparam logic [2:0]       OCT_RESET_C = 3'(OCT_RESET);
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
    localparam logic [31:0]      UNIT_C      = 32'(UNIT_CYCLES);
    localparam logic [31:0]      GAP_C       = 32'(GAP_CYCLES);

    // Octave-4 half-periods in clock cycles, C..B.
    localparam logic [31:0] BASE_TBL [7] = '{
        32'(CLK_HZ / (2 * 262)), 32'(CLK_HZ / (2 * 294)), 32'(CLK_HZ / (2 * 330)),
        32'(CLK_HZ / (2 * 349)), 32'(CLK_HZ / (2 * 392)), 32'(CLK_HZ / (2 * 440)),
        32'(CLK_HZ / (2 * 494))
    };

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]       r_state;
    logic             r_hit_q, r_up_q, r_down_q;
    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_octave;
    logic             r_buzzer, r_busy, r_ovf, r_rest;
    logic [NOTES-1:0] r_led;
    logic [31:0]      r_dur_cnt, r_gap_cnt, r_tone_cnt, r_half;

    logic             w_clear;
    logic             w_hit_edge, w_up_edge, w_down_edge;
    logic             w_empty, w_full, w_pop, w_push_req, w_push_ok, w_drop, w_avail;
    logic [IDX_W-1:0] w_key_idx;
    logic             w_key_rest;
    logic [1:0]       w_len_exp;
    logic [ENT_W-1:0] w_entry, w_head;
    logic [2:0]       w_head_oct;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_rest;
    logic [1:0]       w_head_exp;
    logic [31:0]      w_head_base, w_head_half, w_dur_load;
    logic [NOTES-1:0] w_head_led;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] w_count_next;
    logic [2:0]       w_oct_next;
    logic             w_busy_next;

    // i_en low behaves like a reset of everything except the edge history.
    assign w_clear     = i_rst | ~i_en;
    assign w_hit_edge  = i_hit & ~r_hit_q;
    assign w_up_edge   = i_oct_up & ~r_up_q;
    assign w_down_edge = i_oct_down & ~r_down_q;

    assign w_empty    = (r_count == {CNT_W{1'b0}});
    assign w_full     = (r_count == DEPTH_C);
    assign w_pop      = (r_state == S_LOAD) && !w_empty;
    assign w_push_req = i_en & w_hit_edge;
    // A full queue still accepts a push in the cycle it is being popped.
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    // Looking at the incoming push lets IDLE reach LOAD one cycle after the hit.
    assign w_avail    = !w_empty || w_push_ok;

    // Lowest set key bit wins for both the note and the length selects.
    always_comb begin
        w_key_idx  = {IDX_W{1'b0}};
        w_key_rest = 1'b1;
        w_len_exp  = 2'd0;
        for (int i = NOTES - 1; i >= 0; i--) begin
            w_key_idx  = i_note_key[i] ? IDX_W'(i) : w_key_idx;
            w_key_rest = i_note_key[i] ? 1'b0 : w_key_rest;
        end
        for (int i = 3; i >= 0; i--) begin
            w_len_exp = i_len_key[i] ? 2'(i) : w_len_exp;
        end
    end

    assign w_entry = {r_octave, w_key_idx, w_key_rest, w_len_exp};
    assign w_head  = r_mem[r_rd_ptr];
    assign {w_head_oct, w_head_idx, w_head_rest, w_head_exp} = w_head;

    // Tone half-period of the queue head; keys past B wrap onto the 7-entry table.
    always_comb begin
        w_head_base = 32'd0;
        for (int i = 0; i < NOTES; i++) begin
            w_head_base = (w_head_idx == IDX_W'(i)) ? BASE_TBL[i % 7] : w_head_base;
        end
        if (w_head_oct >= 3'd4) begin
            w_head_half = w_head_base >> (w_head_oct - 3'd4);
        end else begin
            w_head_half = w_head_base << (3'd4 - w_head_oct);
        end
    end

    assign w_head_led = w_head_rest ? {NOTES{1'b0}} : (NOTES'(1) << w_head_idx);
    assign w_dur_load = (UNIT_C << w_head_exp) - 32'd1;

    // Player FSM next-state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_avail) w_state_next = S_LOAD;
                else         w_state_next = S_IDLE;
            end
            S_LOAD: w_state_next = S_PLAY;
            S_PLAY: begin
                if (r_dur_cnt != 32'd0) w_state_next = S_PLAY;
                else if (GAP_C != 32'd0) w_state_next = S_GAP;
                else if (w_avail)        w_state_next = S_LOAD;
                else                     w_state_next = S_IDLE;
            end
            S_GAP: begin
                if (r_gap_cnt != 32'd0) w_state_next = S_GAP;
                else if (w_avail)       w_state_next = S_LOAD;
                else                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Queue occupancy, saturating octave and the registered busy flag.
    always_comb begin
        case ({w_push_ok, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
        if (w_up_edge && !w_down_edge && (r_octave < OCT_MAX_C)) begin
            w_oct_next = r_octave + 3'd1;
        end else if (w_down_edge && !w_up_edge && (r_octave > OCT_MIN_C)) begin
            w_oct_next = r_octave - 3'd1;
        end else begin
            w_oct_next = r_octave;
        end
        w_busy_next = (w_state_next != S_IDLE) || (w_count_next != {CNT_W{1'b0}});
    end

    // Edge-detector history keeps tracking the inputs even while disabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hit_q  <= 1'b0;
            r_up_q   <= 1'b0;
            r_down_q <= 1'b0;
        end else begin
            r_hit_q  <= i_hit;
            r_up_q   <= i_oct_up;
            r_down_q <= i_oct_down;
        end
    end

    // Queue storage; contents need no reset because r_count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push_ok && !w_clear) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Queue pointers, octave, FSM and player outputs.
    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_octave   <= OCT_RESET_C;
            r_buzzer   <= 1'b0;
            r_led      <= {NOTES{1'b0}};
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_rest     <= 1'b0;
            r_dur_cnt  <= 32'd0;
            r_gap_cnt  <= 32'd0;
            r_tone_cnt <= 32'd0;
            r_half     <= 32'd0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_octave <= w_oct_next;
            r_busy   <= w_busy_next;
            r_ovf    <= w_drop;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case (r_state)
                S_LOAD: begin
                    r_led      <= w_head_led;
                    r_rest     <= w_head_rest;
                    r_half     <= w_head_half;
                    r_dur_cnt  <= w_dur_load;
                    r_tone_cnt <= 32'd0;
                    r_buzzer   <= 1'b0;
                end
                S_PLAY: begin
                    if (r_dur_cnt == 32'd0) begin
                        r_led     <= {NOTES{1'b0}};
                        r_buzzer  <= 1'b0;
                        r_gap_cnt <= GAP_C - 32'd1;
                    end else begin
                        r_dur_cnt <= r_dur_cnt - 32'd1;
                        // '>=' also covers a zero half-period by toggling every cycle.
                        if (!r_rest && ((r_tone_cnt + 32'd1) >= r_half)) begin
                            r_buzzer   <= ~r_buzzer;
                            r_tone_cnt <= 32'd0;
                        end else begin
                            r_tone_cnt <= r_tone_cnt + 32'd1;
                        end
                    end
                end
                S_GAP: r_gap_cnt <= r_gap_cnt - 32'd1;
                default: r_gap_cnt <= r_gap_cnt;
            endcase
        end
    end

    assign o_buzzer     = r_buzzer;
    assign o_led        = r_led;
    assign o_octave     = r_octave;
    assign o_busy       = r_busy;
    assign o_fifo_count = r_count;
    assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_freemode_seq.sv
// ---------------------------------------------------------------------------
// tb_freemode_seq
//   Directed bench for freemode_seq at CLK_HZ=8800, UNIT_CYCLES=40,
//   GAP_CYCLES=4, DEPTH=4 (A4 half-period 10, C4 half-period 16).
//   Cycle n counts posedges after the hit is driven; n=1 is the edge that
//   samples the hit. Outputs are sampled 1 time unit after each posedge.
// ---------------------------------------------------------------------------
module tb_freemode_seq;

    logic       clk = 1'b0;
    logic       rst, en, hit, oct_up, oct_down;
    logic [6:0] note_key;
    logic [3:0] len_key;
    logic       buzzer, busy, ovf;
    logic [6:0] led;
    logic [2:0] octave;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    freemode_seq #(
        .NOTES(7), .CLK_HZ(8800), .UNIT_CYCLES(40), .GAP_CYCLES(4), .DEPTH(4),
        .OCT_MIN(1), .OCT_MAX(7), .OCT_RESET(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_hit(hit),
        .i_oct_up(oct_up), .i_oct_down(oct_down),
        .i_note_key(note_key), .i_len_key(len_key),
        .o_buzzer(buzzer), .o_led(led), .o_octave(octave), .o_busy(busy),
        .o_fifo_count(fifo_count), .o_ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; hit = 1'b0; oct_up = 1'b0; oct_down = 1'b0;
        note_key = 7'd0; len_key = 4'd0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({buzzer, led, busy, ovf} !== 10'd0) $display("FAIL reset_outputs: got buz=%b led=%b busy=%b ovf=%b, expected all 0", buzzer, led, busy, ovf);
        else n_pass++;
        n_checks++;
        if (octave !== 3'd4) $display("FAIL reset_octave: got %0d expected 4", octave);
        else n_pass++;
        n_checks++;
        if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count);
        else n_pass++;
    endtask

    task automatic test_single_note();
        int n, t0;
        logic [6:0] el;
        logic eb, ebusy;
        do_reset();
        note_key = 7'b0100000; len_key = 4'b0001; hit = 1'b1; t0 = cyc;
        for (int k = 0; k < 48; k++) begin
            tick(); n = cyc - t0;
            if (n == 1) hit = 1'b0;
            el    = (n >= 2 && n <= 41) ? 7'b0100000 : 7'd0;
            eb    = ((n >= 12 && n < 22) || (n >= 32 && n < 42));
            ebusy = (n >= 1 && n <= 45);
            n_checks++;
            if (led !== el || buzzer !== eb || busy !== ebusy)
                $display("FAIL single_note n=%0d: led=%b exp %b, buz=%b exp %b, busy=%b exp %b", n, led, el, buzzer, eb, busy, ebusy);
            else n_pass++;
            if (n == 1 || n == 2) begin
                n_checks++;
                if (fifo_count !== ((n == 1) ? 3'd1 : 3'd0)) $display("FAIL single_count n=%0d: got %0d exp %0d", n, fifo_count, (n == 1) ? 1 : 0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_octave();
        int n, t0, w;
        logic eb;
        logic [6:0] el;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            oct_up = 1'b1; tick(); oct_up = 1'b0; tick();
        end
        n_checks++;
        if (octave !== 3'd7) $display("FAIL oct_up_sat: got %0d expected 7", octave);
        else n_pass++;
        // A at octave 7: half-period 1, ten down pulses while it plays
        note_key = 7'b0100000; len_key = 4'b0001; hit = 1'b1; t0 = cyc;
        for (int k = 0; k < 40; k++) begin
            tick(); n = cyc - t0;
            if (n == 1) hit = 1'b0;
            if (n >= 2) begin
                eb = ((n - 2) % 2) == 1;
                n_checks++;
                if (buzzer !== eb || led !== 7'b0100000) $display("FAIL oct7_tone n=%0d: buz=%b exp %b led=%b", n, buzzer, eb, led);
                else n_pass++;
            end
            oct_down = (n >= 6 && n <= 24 && (n % 2) == 0);
        end
        n_checks++;
        if (octave !== 3'd1) $display("FAIL oct_down_sat: got %0d expected 1", octave);
        else n_pass++;
        w = 0;
        while (busy !== 1'b0 && w < 100) begin tick(); w++; end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL oct_idle_wait: busy=%b expected 0 within 100 cycles", busy);
        else n_pass++;
        oct_up = 1'b1; tick(); oct_up = 1'b0; tick();
        oct_up = 1'b1; oct_down = 1'b1; tick(); oct_up = 1'b0; oct_down = 1'b0; tick();
        n_checks++;
        if (octave !== 3'd2) $display("FAIL oct_both: got %0d expected 2", octave);
        else n_pass++;
        // A at octave 2, two units: half-period 40, first rise at n=42
        note_key = 7'b0100000; len_key = 4'b0010; hit = 1'b1; t0 = cyc;
        for (int k = 0; k < 84; k++) begin
            tick(); n = cyc - t0;
            if (n == 1) hit = 1'b0;
            el = (n >= 2 && n <= 81) ? 7'b0100000 : 7'd0;
            eb = (n >= 42 && n <= 81);
            n_checks++;
            if (led !== el || buzzer !== eb) $display("FAIL oct2_tone n=%0d: led=%b exp %b buz=%b exp %b", n, led, el, buzzer, eb);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        int n, t0, eci, kk, off;
        logic [2:0] ec;
        logic [6:0] el;
        logic eo, ebusy;
        logic [6:0] lseq [6] = '{7'b0000001, 7'b0000010, 7'b0000100,
                                 7'b0001000, 7'b0010000, 7'b0100000};
        do_reset();
        note_key = 7'b0000001; len_key = 4'b0001; hit = 1'b1; t0 = cyc;
        for (int k = 0; k < 275; k++) begin
            tick(); n = cyc - t0;
            if (n == 1) eci = 1;
            else if (n == 2) eci = 0;
            else if (n <= 11) eci = ((n - 1) / 2 > 4) ? 4 : (n - 1) / 2;
            else begin
                eci = 4;
                for (int j = 2; j <= 5; j++) if (n >= 2 + 45 * j) eci--;
            end
            ec = 3'(eci);
            eo = (n == 11);
            el = 7'd0;
            if (n >= 2) begin
                kk = (n - 2) / 45; off = (n - 2) % 45;
                if (kk < 6 && off < 40) el = lseq[kk];
            end
            ebusy = (n <= 270);
            n_checks++;
            if (fifo_count !== ec || ovf !== eo || led !== el || busy !== ebusy)
                $display("FAIL overflow n=%0d: count=%0d exp %0d ovf=%b exp %b led=%b exp %b busy=%b exp %b",
                         n, fifo_count, ec, ovf, eo, led, el, busy, ebusy);
            else n_pass++;
            case (n)
                1, 3, 5, 7, 9, 11, 47: hit = 1'b0;
                2:  begin note_key = 7'b0000010; hit = 1'b1; end
                4:  begin note_key = 7'b0000100; hit = 1'b1; end
                6:  begin note_key = 7'b0001000; hit = 1'b1; end
                8:  begin note_key = 7'b0010000; hit = 1'b1; end
                10: begin note_key = 7'b1000000; hit = 1'b1; end
                46: begin note_key = 7'b0100000; hit = 1'b1; end
                default: hit = hit;
            endcase
        end
    endtask

    task automatic test_rest();
        int n, t0;
        logic ebusy;
        do_reset();
        note_key = 7'd0; len_key = 4'b0100; hit = 1'b1; t0 = cyc;
        for (int k = 0; k < 170; k++) begin
            tick(); n = cyc - t0;
            if (n == 1) hit = 1'b0;
            ebusy = (n <= 165);
            n_checks++;
            if (buzzer !== 1'b0 || led !== 7'd0 || busy !== ebusy)
                $display("FAIL rest n=%0d: buz=%b led=%b busy=%b exp busy %b", n, buzzer, led, busy, ebusy);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        int n, t0;
        do_reset();
        oct_up = 1'b1; tick(); oct_up = 1'b0; tick();
        // C at octave 5: half-period 8, buzzer high from n=10
        note_key = 7'b0000001; len_key = 4'b0001; hit = 1'b1; t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            tick(); n = cyc - t0;
            hit = (n == 2 || n == 4);
            if (n == 2) note_key = 7'b0000010;
            if (n == 4) note_key = 7'b0000100;
        end
        n_checks++;
        if (led !== 7'b0000001 || buzzer !== 1'b1 || fifo_count !== 3'd2 || octave !== 3'd5)
            $display("FAIL abort_before: led=%b buz=%b count=%0d oct=%0d, expected 0000001 1 2 5", led, buzzer, fifo_count, octave);
        else n_pass++;
        en = 1'b0;
        tick();
        n_checks++;
        if (buzzer !== 1'b0 || led !== 7'd0 || fifo_count !== 3'd0 || busy !== 1'b0 || octave !== 3'd4)
            $display("FAIL abort_after: buz=%b led=%b count=%0d busy=%b oct=%0d, expected 0 0 0 0 4", buzzer, led, fifo_count, busy, octave);
        else n_pass++;
        // hit edge while disabled, held high across re-enable: nothing queues
        note_key = 7'b1000000; hit = 1'b1; tick(); tick();
        en = 1'b1; tick(); tick(); hit = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            n_checks++;
            if (led !== 7'd0 || busy !== 1'b0 || fifo_count !== 3'd0 || buzzer !== 1'b0)
                $display("FAIL abort_reenable k=%0d: led=%b busy=%b count=%0d buz=%b, expected all 0", k, led, busy, fifo_count, buzzer);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; hit = 1'b0; oct_up = 1'b0; oct_down = 1'b0;
        note_key = 7'd0; len_key = 4'd0;
        test_reset();
        test_single_note();
        test_octave();
        test_overflow();
        test_rest();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
